// File: rtl/pc_gen_if.sv
// Control-flow bus between the decode stage and the PC generator.
interface pc_gen_if;
  logic        stall;
  logic [2:0]  br_type;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [25:0] imm26;
  logic        jal;
  logic        jr;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        taken;
  logic        pend_valid;
  logic        ctrl_err;

  modport master (
    output stall, br_type, rs_val, rt_val, imm26, jal, jr,
    input  pc, link_addr, taken, pend_valid, ctrl_err
  );

  modport slave (
    input  stall, br_type, rs_val, rt_val, imm26, jal, jr,
    output pc, link_addr, taken, pend_valid, ctrl_err
  );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator: branch/jump/jr redirect with optional one-slot
// architectural delay, where the pending target is held in a PEND state.
module pc_gen #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          DELAY_SLOT = 0
) (
  input logic      clk,
  input logic      reset,
  pc_gen_if.slave  bus
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        tgt_q, tgt_d;
  logic signed [31:0] rs_s;
  logic [31:0]        pc_plus4;
  logic [31:0]        br_off;
  logic [31:0]        br_target;
  logic [31:0]        j_target;
  logic [31:0]        sel_target;
  logic               cond;
  logic               req;
  logic               taken;
  logic               ctrl_err;

  assign rs_s = bus.rs_val;

  always_comb begin
    cond = 1'b0;
    case (bus.br_type)
      3'd1:    cond = (bus.rs_val == bus.rt_val);
      3'd2:    cond = (bus.rs_val != bus.rt_val);
      3'd3:    cond = (rs_s <= 32'sd0);
      3'd4:    cond = (rs_s >  32'sd0);
      3'd5:    cond = (rs_s <  32'sd0);
      3'd6:    cond = (rs_s >= 32'sd0);
      default: cond = 1'b0;
    endcase
  end

  assign pc_plus4   = pc_q + 32'd4;
  assign br_off     = {{14{bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
  assign br_target  = pc_plus4 + br_off;
  assign j_target   = {pc_plus4[31:28], bus.imm26, 2'b00};
  assign req        = bus.jr | bus.jal | cond;
  // jr outranks jal, which outranks a taken branch
  assign sel_target = bus.jr ? bus.rs_val : (bus.jal ? j_target : br_target);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    taken    = 1'b0;
    ctrl_err = 1'b0;
    if (!reset && !bus.stall) begin
      if (state_q == PEND) begin
        // delay slot is executing: retire the held target, refuse new control
        pc_d     = tgt_q;
        state_d  = IDLE;
        ctrl_err = req;
      end else begin
        taken = req;
        if (req && (DELAY_SLOT != 0)) begin
          pc_d    = pc_plus4;
          tgt_d   = sel_target;
          state_d = PEND;
        end else if (req) begin
          pc_d = sel_target;
        end else begin
          pc_d = pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.link_addr  = pc_q + ((DELAY_SLOT != 0) ? 32'd8 : 32'd4);
  assign bus.taken      = taken;
  assign bus.ctrl_err   = ctrl_err;
  assign bus.pend_valid = (DELAY_SLOT != 0) && (state_q == PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: one instance per delay-slot mode driven in parallel,
// checked every cycle against a behavioural model plus directed literals.
module tb_pc_gen;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall;
  logic [2:0]  br_type;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [25:0] imm26;
  logic        jal;
  logic        jr;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc   [2];
  logic        m_pend [2];
  logic [31:0] m_tgt  [2];

  pc_gen_if if0 ();
  pc_gen_if if1 ();

  assign if0.stall = stall;   assign if1.stall = stall;
  assign if0.br_type = br_type; assign if1.br_type = br_type;
  assign if0.rs_val = rs_val; assign if1.rs_val = rs_val;
  assign if0.rt_val = rt_val; assign if1.rt_val = rt_val;
  assign if0.imm26 = imm26;   assign if1.imm26 = imm26;
  assign if0.jal = jal;       assign if1.jal = jal;
  assign if0.jr = jr;         assign if1.jr = jr;

  pc_gen #(.RESET_PC(RST_PC), .DELAY_SLOT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  pc_gen #(.RESET_PC(RST_PC), .DELAY_SLOT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  function automatic logic m_req(input logic [2:0] bt, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic j, input logic r);
    int signed v;
    logic c;
    v = $signed(rs);
    case (bt)
      3'd1: c = (rs == rt);
      3'd2: c = (rs != rt);
      3'd3: c = (v <= 0);
      3'd4: c = (v > 0);
      3'd5: c = (v < 0);
      3'd6: c = (v >= 0);
      default: c = 1'b0;
    endcase
    return j | r | c;
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] p);
    int signed off;
    logic [31:0] nxt;
    nxt = p + 32'd4;
    off = $signed(imm26[15:0]);
    if (jr) return rs_val;
    if (jal) return {nxt[31:28], imm26, 2'b00};
    return nxt + 32'(off * 4);
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_pc[d] = RST_PC; m_pend[d] = 1'b0; m_tgt[d] = 32'd0;
      end else if (!stall) begin
        if (m_pend[d]) begin
          m_pc[d] = m_tgt[d]; m_pend[d] = 1'b0;
        end else if (m_req(br_type, rs_val, rt_val, jal, jr)) begin
          if (d == 1) begin
            m_tgt[d] = m_target(m_pc[d]); m_pc[d] = m_pc[d] + 32'd4; m_pend[d] = 1'b1;
          end else begin
            m_pc[d] = m_target(m_pc[d]);
          end
        end else begin
          m_pc[d] = m_pc[d] + 32'd4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checks >= 0 && $time > 2) begin
      logic rq, ok;
      rq = m_req(br_type, rs_val, rt_val, jal, jr);
      ok = !reset && !stall;
      chk("m0_pc",    if0.pc,         m_pc[0]);
      chk("m0_pend",  32'(if0.pend_valid), 32'd0);
      chk("m0_taken", 32'(if0.taken),  32'(ok && !m_pend[0] && rq));
      chk("m0_err",   32'(if0.ctrl_err), 32'(ok && m_pend[0] && rq));
      chk("m0_link",  if0.link_addr,  m_pc[0] + 32'd4);
      chk("m1_pc",    if1.pc,         m_pc[1]);
      chk("m1_pend",  32'(if1.pend_valid), 32'(m_pend[1]));
      chk("m1_taken", 32'(if1.taken),  32'(ok && !m_pend[1] && rq));
      chk("m1_err",   32'(if1.ctrl_err), 32'(ok && m_pend[1] && rq));
      chk("m1_link",  if1.link_addr,  m_pc[1] + 32'd8);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    br_type = 3'd0; rs_val = 32'd0; rt_val = 32'd0; imm26 = 26'd0; jal = 1'b0; jr = 1'b0;
  endtask

  task automatic goto0(input logic [31:0] a);
    jr = 1'b1; rs_val = a;
    step();
    clr();
  endtask

  initial begin
    stall = 1'b0;
    clr();
    #1 reset = 1'b1;
    jal = 1'b1;
    step(); step();
    chk("rst_pc0", if0.pc, 32'h3000);
    chk("rst_pc1", if1.pc, 32'h3000);
    chk("rst_pend1", 32'(if1.pend_valid), 32'd0);
    chk("rst_taken0", 32'(if0.taken), 32'd0);
    jal = 1'b0;
    reset = 1'b0;
    #1 chk("seq_pc0_0", if0.pc, 32'h3000);
    step(); chk("seq_pc0_1", if0.pc, 32'h3004);
    step(); chk("seq_pc0_2", if0.pc, 32'h3008);
    step(); chk("seq_pc0_3", if0.pc, 32'h300C);
    chk("seq_pc1_3", if1.pc, 32'h300C);

    goto0(32'h3010);
    br_type = 3'd1; rs_val = 32'd5; rt_val = 32'd5; imm26 = 26'h000FFFC;
    #1 chk("beq_taken", 32'(if0.taken), 32'd1);
    step(); chk("beq_pc", if0.pc, 32'h3004);
    clr();
    goto0(32'h3010);
    br_type = 3'd1; rs_val = 32'd5; rt_val = 32'd6; imm26 = 26'h0000003;
    #1 chk("beq_nt_taken", 32'(if0.taken), 32'd0);
    step(); chk("beq_nt_pc", if0.pc, 32'h3014);
    clr();
    goto0(32'h3010);
    br_type = 3'd2; rs_val = 32'd5; rt_val = 32'd6; imm26 = 26'h0000003;
    step(); chk("bne_pc", if0.pc, 32'h3020);
    clr();

    goto0(32'h3020);
    jal = 1'b1; jr = 1'b1; rs_val = 32'h4000; imm26 = 26'h0000C10;
    #1 chk("prio_link", if0.link_addr, 32'h3024);
    step(); chk("prio_pc", if0.pc, 32'h4000);
    clr();
    goto0(32'h3020);
    jal = 1'b1; imm26 = 26'h0000C10;
    step(); chk("jal_pc", if0.pc, 32'h3040);
    clr();

    goto0(32'hFFFF_FFFC);
    chk("wrap_link", if0.link_addr, 32'h0);
    step(); chk("wrap_pc", if0.pc, 32'h0);
    br_type = 3'd5; rs_val = 32'h8000_0000;
    #1 chk("bltz_taken", 32'(if0.taken), 32'd1);
    br_type = 3'd6;
    #1 chk("bgez_taken", 32'(if0.taken), 32'd0);
    br_type = 3'd7; rs_val = 32'd0;
    #1 chk("rsvd_taken", 32'(if0.taken), 32'd0);
    br_type = 3'd3;
    #1 chk("blez0_taken", 32'(if0.taken), 32'd1);
    br_type = 3'd4;
    #1 chk("bgtz0_taken", 32'(if0.taken), 32'd0);
    clr();
    step();

    reset = 1'b1;
    #1 reset = 1'b0;
    chk("ds_start_pc1", if1.pc, 32'h3000);
    jal = 1'b1; imm26 = 26'h0000D00;
    #1 chk("ds_taken", 32'(if1.taken), 32'd1);
    chk("ds_link", if1.link_addr, 32'h3008);
    step();
    chk("ds_slot_pc", if1.pc, 32'h3004);
    chk("ds_slot_pend", 32'(if1.pend_valid), 32'd1);
    jal = 1'b0; stall = 1'b1;
    #1 chk("ds_stall_taken", 32'(if1.taken), 32'd0);
    chk("ds_stall_err", 32'(if1.ctrl_err), 32'd0);
    step(); chk("ds_stall_pc_a", if1.pc, 32'h3004);
    step(); chk("ds_stall_pc_b", if1.pc, 32'h3004);
    chk("ds_stall_pend", 32'(if1.pend_valid), 32'd1);
    stall = 1'b0;
    br_type = 3'd1; rs_val = 32'd1; rt_val = 32'd1;
    #1 chk("ds_slot_err", 32'(if1.ctrl_err), 32'd1);
    chk("ds_slot_taken", 32'(if1.taken), 32'd0);
    step();
    chk("ds_redirect_pc", if1.pc, 32'h3400);
    chk("ds_redirect_pend", 32'(if1.pend_valid), 32'd0);
    clr();

    jal = 1'b1; imm26 = 26'h0000100;
    step();
    clr();
    chk("ds_pend2_pc", if1.pc, 32'h3404);
    chk("ds_pend2_v", 32'(if1.pend_valid), 32'd1);
    reset = 1'b1;
    jal = 1'b1;
    #1 chk("ds_arst_pc", if1.pc, 32'h3000);
    chk("ds_arst_pend", 32'(if1.pend_valid), 32'd0);
    chk("ds_arst_taken", 32'(if1.taken), 32'd0);
    chk("ds_arst_err", 32'(if1.ctrl_err), 32'd0);
    jal = 1'b0;
    reset = 1'b0;
    step();
    chk("ds_post_pc", if1.pc, 32'h3004);
    chk("ds_post_pend", 32'(if1.pend_valid), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
